// File: rtl/alarm_sequencer.sv
// rtl/alarm_sequencer.sv - alarm arming/trigger FSM, DAC config handshake and tone cadence
// Optional feature macro: ALARM_AUTO_RESET_EN (leave ALARM after DEBOUNCE consecutive clear samples)
module alarm_sequencer #(
    parameter logic [7:0] THRESH    = 8'd50,
    parameter logic [7:0] HYST      = 8'd10,
    parameter int         DEBOUNCE  = 4,
    parameter int         ARM_DELAY = 1_000_000,
    parameter int         TONE_DIV  = 25_000,
    parameter int         BEEP_LEN  = 5_000_000,
    parameter logic [7:0] CFG_ON    = 8'hA5,
    parameter logic [7:0] CFG_OFF   = 8'h5A
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] Distance,
    input  logic       Dist_Valid,
    input  logic       Arm,
    input  logic       Silence,
    input  logic       I2C_Ack,
    output logic       I2C_Req,
    output logic [7:0] I2C_Byte,
    output logic       Sound,
    output logic       Alarm_Active,
    output logic [2:0] State
);

`ifdef ALARM_AUTO_RESET_EN
    localparam bit AUTO_RESET = 1'b1;
`else
    localparam bit AUTO_RESET = 1'b0;
`endif

    localparam int AW = $clog2(ARM_DELAY + 1);
    localparam int DW = $clog2(DEBOUNCE + 1);
    localparam int TW = $clog2(TONE_DIV + 1);
    localparam int CW = $clog2(2 * BEEP_LEN + 1);

    localparam logic [AW-1:0] ARM_LAST  = AW'(ARM_DELAY - 1);
    localparam logic [DW-1:0] DEB_N     = DW'(DEBOUNCE);
    localparam logic [TW-1:0] TONE_LAST = TW'(TONE_DIV - 1);
    localparam logic [CW-1:0] CAD_LAST  = CW'(2 * BEEP_LEN - 1);
    localparam logic [CW-1:0] BEEP_N    = CW'(BEEP_LEN);

    // Clear level saturates at 255 so a large THRESH+HYST cannot wrap to a small value.
    localparam logic [8:0] CLR_SUM = {1'b0, THRESH} + {1'b0, HYST};
    localparam logic [7:0] CLR_LVL = CLR_SUM[8] ? 8'hFF : CLR_SUM[7:0];

    typedef enum logic [2:0] {
        DISARMED  = 3'd0,
        ARMING    = 3'd1,
        WATCH     = 3'd2,
        CONFIRM   = 3'd3,
        CFG_ON_S  = 3'd4,
        ALARM     = 3'd5,
        CFG_OFF_S = 3'd6
    } state_t;

    state_t        state, nxt;
    logic [AW-1:0] arm_cnt;
    logic [DW-1:0] deb_cnt, clr_cnt;
    logic [TW-1:0] tone_cnt;
    logic [CW-1:0] cad_cnt, cad_nxt;
    logic          sil_pend;
    logic          close, clear;

    assign close   = Distance < THRESH;
    assign clear   = Distance >= CLR_LVL;
    assign cad_nxt = (cad_cnt == CAD_LAST) ? '0 : cad_cnt + CW'(1);
    assign State   = state;

    always_comb begin
        nxt = state;
        case (state)
            DISARMED:  if (Arm) nxt = ARMING;
            ARMING:    if (!Arm) nxt = DISARMED;
                       else if (arm_cnt == ARM_LAST) nxt = WATCH;
            WATCH:     if (!Arm) nxt = DISARMED;
                       else if (Dist_Valid && close) nxt = (DEBOUNCE == 1) ? CFG_ON_S : CONFIRM;
            CONFIRM:   if (!Arm) nxt = DISARMED;
                       else if (Dist_Valid) begin
                           if (!close) nxt = WATCH;
                           else if (deb_cnt + DW'(1) == DEB_N) nxt = CFG_ON_S;
                       end
            // Arm=0 here does not abort the transfer; ALARM then sees Arm=0 and mutes.
            CFG_ON_S:  if (I2C_Ack) nxt = ALARM;
            ALARM:     if (!Arm || Silence || sil_pend) nxt = CFG_OFF_S;
                       else if (AUTO_RESET && Dist_Valid && clear && (clr_cnt + DW'(1) == DEB_N))
                           nxt = CFG_OFF_S;
            CFG_OFF_S: if (I2C_Ack) nxt = Arm ? WATCH : DISARMED;
            default:   nxt = DISARMED;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state        <= DISARMED;
            arm_cnt      <= '0;
            deb_cnt      <= '0;
            clr_cnt      <= '0;
            tone_cnt     <= '0;
            cad_cnt      <= '0;
            sil_pend     <= 1'b0;
            I2C_Req      <= 1'b0;
            I2C_Byte     <= 8'h00;
            Sound        <= 1'b0;
            Alarm_Active <= 1'b0;
        end else begin
            state        <= nxt;
            Alarm_Active <= (nxt == CFG_ON_S) || (nxt == ALARM) || (nxt == CFG_OFF_S);
            I2C_Req      <= (nxt == CFG_ON_S) || (nxt == CFG_OFF_S);
            if (nxt == CFG_ON_S && state != CFG_ON_S)
                I2C_Byte <= CFG_ON;
            else if (nxt == CFG_OFF_S && state != CFG_OFF_S)
                I2C_Byte <= CFG_OFF;

            arm_cnt <= (state == ARMING && nxt == ARMING) ? arm_cnt + AW'(1) : '0;

            if (nxt == CONFIRM)
                deb_cnt <= (Dist_Valid && close) ? deb_cnt + DW'(1) : deb_cnt;
            else
                deb_cnt <= '0;

            if (state == ALARM && nxt == ALARM) begin
                if (Dist_Valid)
                    clr_cnt <= !clear ? '0 : (clr_cnt == DEB_N) ? clr_cnt : clr_cnt + DW'(1);
            end else begin
                clr_cnt <= '0;
            end

            // A Silence seen during the ON transfer is carried into the first ALARM cycle.
            sil_pend <= (state == CFG_ON_S) && (sil_pend || Silence);

            if (state == ALARM && nxt == ALARM) begin
                cad_cnt <= cad_nxt;
                if (cad_nxt == '0 || cad_nxt >= BEEP_N) begin
                    tone_cnt <= '0;
                    Sound    <= 1'b0;
                end else if (tone_cnt == TONE_LAST) begin
                    tone_cnt <= '0;
                    Sound    <= ~Sound;
                end else begin
                    tone_cnt <= tone_cnt + TW'(1);
                end
            end else begin
                cad_cnt  <= '0;
                tone_cnt <= '0;
                Sound    <= 1'b0;
            end
        end
    end

endmodule
